// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 32-bit ALU and its arbiter front end.
//   ALU_CTRL_W        : width of the ALU control field
//   ALU_ADD..ALU_OR   : ALU control encodings (100..111 are undefined and yield 0)
//   arb_state_t       : arbiter FSM state encoding
package alu_pkg;

   localparam int ALU_CTRL_W = 3;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/alu.sv
// alu: purely combinational ALU (ADD/SUB/AND/OR), wrap-around arithmetic.
//   a, b   in  operands
//   ctl    in  operation select (alu_pkg encodings)
//   result out operation result (0 for undefined opcodes)
//   zero   out result == 0
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   input  logic [ALU_CTRL_W-1:0] ctl,
   output logic [DATA_W-1:0]     result,
   output logic                  zero
);

   always_comb begin
      result = '0;
      case (ctl)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         default: result = '0;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between NREQ requesters with round-robin arbitration.
//   clk, rst    clock and asynchronous active-high reset
//   req_valid   per-requester request valid
//   req_ready   request accepted this cycle (IDLE only, at most one bit)
//   req_a/b     packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_op      packed ALU control, requester i at [i*3 +: 3]
//   rsp_valid   one-hot result valid for the granted requester (RESP)
//   rsp_ready   per-requester result accept; only the granted bit matters
//   rsp_result  registered ALU result, rsp_zero registered zero flag
//   busy        high in EXEC or RESP
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int DATA_W = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREQ-1:0]              req_valid,
   output logic [NREQ-1:0]              req_ready,
   input  logic [NREQ*DATA_W-1:0]       req_a,
   input  logic [NREQ*DATA_W-1:0]       req_b,
   input  logic [NREQ*ALU_CTRL_W-1:0]   req_op,
   output logic [NREQ-1:0]              rsp_valid,
   input  logic [NREQ-1:0]              rsp_ready,
   output logic [DATA_W-1:0]            rsp_result,
   output logic                         rsp_zero,
   output logic                         busy
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [GW-1:0] LAST_REQ = GW'(NREQ - 1);

   arb_state_t state, state_next;

   logic [GW-1:0]         gnt;
   logic [GW-1:0]         last_gnt;
   logic [GW-1:0]         win;
   logic                  any_valid;
   logic [DATA_W-1:0]     op_a;
   logic [DATA_W-1:0]     op_b;
   logic [ALU_CTRL_W-1:0] op_ctl;
   logic [DATA_W-1:0]     alu_result;
   logic                  alu_zero;
   logic                  accept;

   // Round-robin search: start just after the last grant and wrap.
   always_comb begin
      win       = '0;
      any_valid = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!any_valid && req_valid[(int'(last_gnt) + k) % NREQ]) begin
            any_valid = 1'b1;
            win       = GW'((int'(last_gnt) + k) % NREQ);
         end
      end
   end

   assign accept = (state == IDLE) && any_valid;

   always_comb begin
      state_next = state;
      req_ready  = '0;
      rsp_valid  = '0;
      case (state)
         IDLE: begin
            if (any_valid) state_next = EXEC;
            // Gate with rst so nothing appears accepted while reset is held.
            if (any_valid && !rst) req_ready[win] = 1'b1;
         end
         EXEC: state_next = RESP;
         RESP: begin
            rsp_valid[gnt] = 1'b1;
            if (rsp_ready[gnt]) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         gnt        <= '0;
         last_gnt   <= LAST_REQ;
         op_a       <= '0;
         op_b       <= '0;
         op_ctl     <= '0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            op_a     <= req_a[int'(win)*DATA_W +: DATA_W];
            op_b     <= req_b[int'(win)*DATA_W +: DATA_W];
            op_ctl   <= req_op[int'(win)*ALU_CTRL_W +: ALU_CTRL_W];
            gnt      <= win;
            last_gnt <= win;
         end
         if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
         end
      end
   end

   alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a      (op_a),
      .b      (op_b),
      .ctl    (op_ctl),
      .result (alu_result),
      .zero   (alu_zero)
   );

endmodule
